// File: rtl/slave_reg_ctrl_pkg.sv
// Shared definitions for the I2C slave register block.
// Holds the FSM state encoding, register-file geometry (count, pointer
// width, data width) and the bit positions inside the sticky err vector.
package slave_reg_ctrl_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_REGS  = 8;
  localparam int PTR_W     = 3;
  localparam int ERR_W     = 2;
  localparam int ERR_RANGE = 0;  // pointer byte had bits above the index range
  localparam int ERR_RO    = 1;  // master tried to write the read-only chip ID

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    ST_PTR  = 1'b0,  // next received byte is a register pointer
    ST_DATA = 1'b1   // next received byte is write data
  } state_t;

  // Pointer auto-increment; the natural 3-bit overflow gives the 7 -> 0 wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/slave_reg_ctrl_edge_det.sv
// Rising-edge detector for the level handshakes coming from the I2C byte
// engine. The previous level is registered every cycle.
//   clk, reset : clock and synchronous active-high reset
//   level      : level input from the byte engine
//   evt        : one-cycle pulse when level goes 0 -> 1
module i2c_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic evt
);

  logic last;

  always_ff @(posedge clk) begin
    if (reset) last <= 1'b0;
    else       last <= level;
  end

  assign evt = level & ~last;

endmodule

// File: rtl/slave_reg_ctrl.sv
// Register-file front end for an I2C slave byte engine.
// The master writes a pointer byte followed by data bytes (auto-increment);
// master reads stream reg[pointer] out through datasend. A local host port
// gives a parallel read/write path to the same registers. reg0 is a
// read-only chip ID.
//   clk, reset              : clock, synchronous active-high reset
//   received, datareceive   : byte-received level and byte from the engine
//   sended                  : byte-sent level from the engine
//   stop                    : STOP / repeated START pulse
//   datasend                : byte for the next master read
//   address                 : slave address for the engine
//   host_we/addr/wdata      : local write port
//   host_rdata              : registered local read data
//   wr_strobe, wr_index     : pulse and index for each accepted I2C write
//   err                     : sticky error flags (range, read-only write)
module slave_reg_ctrl
  import slave_reg_ctrl_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h3C,
  parameter logic [7:0] CHIP_ID       = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              received,
  input  logic [DATA_W-1:0] datareceive,
  input  logic              sended,
  input  logic              stop,
  output logic [DATA_W-1:0] datasend,
  output logic [6:0]        address,
  input  logic              host_we,
  input  logic [PTR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              wr_strobe,
  output logic [PTR_W-1:0]  wr_index,
  output logic [ERR_W-1:0]  err
);

  state_t            state, state_n;
  ptr_t              ptr, ptr_n;
  logic              rx_evt, tx_evt;
  logic              i2c_we;
  logic [ERR_W-1:0]  err_set;
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] rd_ptr, rd_host;

  assign address = SLAVE_ADDRESS;

  i2c_edge_det u_rx_edge (
    .clk   (clk),
    .reset (reset),
    .level (received),
    .evt   (rx_evt)
  );

  i2c_edge_det u_tx_edge (
    .clk   (clk),
    .reset (reset),
    .level (sended),
    .evt   (tx_evt)
  );

  // Priority: stop > rx_evt > tx_evt. stop discards a same-cycle byte and
  // keeps the pointer; a byte received together with a send edge wins.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    i2c_we  = 1'b0;
    err_set = '0;
    if (stop) begin
      state_n = ST_PTR;
    end else if (rx_evt) begin
      case (state)
        ST_PTR: begin
          ptr_n = datareceive[PTR_W-1:0];
          if (|datareceive[DATA_W-1:PTR_W]) err_set[ERR_RANGE] = 1'b1;
          state_n = ST_DATA;
        end
        ST_DATA: begin
          // The chip ID is never overwritten, but the pointer still advances
          // so a burst keeps its alignment with the master's view.
          if (ptr == '0) err_set[ERR_RO] = 1'b1;
          else           i2c_we = 1'b1;
          ptr_n = ptr_inc(ptr);
        end
        default: state_n = ST_PTR;
      endcase
    end else if (tx_evt) begin
      ptr_n = ptr_inc(ptr);
    end
  end

  // Read muxes for the I2C pointer and the host index; index 0 is the ID.
  always_comb begin
    rd_ptr  = CHIP_ID;
    rd_host = CHIP_ID;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ptr == ptr_t'(i))       rd_ptr  = regs[i];
      if (host_addr == ptr_t'(i)) rd_host = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_PTR;
      ptr        <= '0;
      datasend   <= '0;
      host_rdata <= '0;
      wr_strobe  <= 1'b0;
      wr_index   <= '0;
      err        <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      datasend   <= rd_ptr;
      host_rdata <= rd_host;
      wr_strobe  <= i2c_we;
      if (i2c_we) wr_index <= ptr;
      err        <= err | err_set;
    end
  end

  // Register file: the I2C write is checked first so it wins a collision
  // with a host write to the same index.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reset)                                   regs[i] <= '0;
      else if (i2c_we && ptr == ptr_t'(i))         regs[i] <= datareceive;
      else if (host_we && host_addr == ptr_t'(i))  regs[i] <= host_wdata;
    end
  end

endmodule

// File: doc/slave_reg_ctrl.md
SLAVE_REG_CTRL -- requirements
Module: slave_reg_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h3C: 7-bit I2C slave address presented to the byte engine.
REQ-002 SHALL have parameter CHIP_ID, default 8'hA5: read-only contents of register 0.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 received  in  1  level from byte engine; a rising edge means datareceive holds a new byte.
REQ-006 datareceive  in  8  byte received from the I2C master.
REQ-007 sended  in  1  level from byte engine; a rising edge means datasend was shifted out to the master.
REQ-008 stop  in  1  one-cycle pulse on I2C STOP/repeated START.
REQ-009 datasend  out  8  byte for the next master read.
REQ-010 address  out  7  constant SLAVE_ADDRESS.
REQ-011 host_we  in  1  local write strobe.
REQ-012 host_addr  in  3  local register index.
REQ-013 host_wdata  in  8  local write data.
REQ-014 host_rdata  out  8  registered local read data.
REQ-015 wr_strobe  out  1  one-cycle pulse on each accepted I2C register write.
REQ-016 wr_index  out  3  register index of the last I2C write.
REQ-017 err  out  2  sticky flags: [0] pointer out of range, [1] write to read-only register.

Function
REQ-018 SHALL hold eight 8-bit registers: reg0 = CHIP_ID (read-only), reg1..reg7 read/write.
REQ-019 SHALL detect edges as rx_evt = received & ~last_received and tx_evt = sended & ~last_sended, and SHALL update both last_* registers every cycle.
REQ-020 SHALL implement FSM states PTR (expect register pointer) and DATA (expect write data).
REQ-021 In PTR on rx_evt: pointer <= datareceive[2:0]; err[0] set if datareceive[7:3] != 0; state -> DATA.
REQ-022 In DATA on rx_evt: reg[pointer] <= datareceive; wr_strobe = 1 and wr_index = pointer on the next cycle; pointer <= pointer+1, wrapping 7 -> 0.
REQ-023 In DATA on rx_evt with pointer == 0: the write SHALL be dropped, err[1] SHALL set, no wr_strobe SHALL be issued, and the pointer SHALL still increment.
REQ-024 On tx_evt in either state: pointer <= pointer+1, wrapping 7 -> 0; the state SHALL not change.
REQ-025 datasend SHALL equal reg[pointer] registered each cycle, i.e. it lags a pointer or register change by one cycle.
REQ-026 stop SHALL force the state to PTR, retain the pointer, and take priority over a same-cycle rx_evt (that byte is discarded).
REQ-027 If rx_evt and tx_evt occur in the same cycle, rx_evt SHALL be processed and tx_evt SHALL be dropped.
REQ-028 host_we SHALL write reg[host_addr] <= host_wdata; writes to index 0 SHALL be ignored without setting an err flag.
REQ-029 If a host write and an I2C write target the same register in the same cycle, the I2C write SHALL win.
REQ-030 host_rdata SHALL be reg[host_addr] registered, with one-cycle latency.
REQ-031 err bits SHALL clear only on reset.

Reset
REQ-032 While reset is high: state = PTR, pointer = 0, reg1..reg7 = 8'h00, last_received = last_sended = 0, datasend = 8'h00, host_rdata = 8'h00, wr_strobe = 0, wr_index = 0, err = 2'b00.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no partial write; datasend SHALL show CHIP_ID on the second cycle after reset deasserts.

Structure
REQ-034 State encodings, register count (8), pointer width (3) and error bit positions SHALL live in the shared I2C package/header.
REQ-035 SHALL instantiate one sub-module, i2c_edge_det, used twice for the rx_evt and tx_evt edge detection.

Verification
REQ-036 Master writes 8'h03, 8'h5A, 8'h77 -> reg3 = 8'h5A, reg4 = 8'h77, two wr_strobe pulses with wr_index 3 then 4, pointer = 5.
REQ-037 Master writes pointer 8'h00, then three reads (tx_evt x3) -> datasend sequence 8'hA5, reg1, reg2.
REQ-038 Master writes pointer 8'h07 and data 8'h11, 8'h22 -> reg7 = 8'h11; the write to reg0 is dropped, err = 2'b10, pointer = 1.
REQ-039 Master writes pointer 8'h0C -> pointer = 4, err[0] = 1.
REQ-040 rx_evt and stop in the same cycle while in DATA -> no write, state = PTR; separately, a same-cycle host write of 8'h33 and I2C write of 8'h44 to reg2 -> reg2 = 8'h44.
REQ-041 Reset asserted between the pointer byte and the data byte -> all reg1..reg7 = 0, state = PTR, no wr_strobe issued.
